// File: rtl/dff_pipe_en.sv
// ============================================================================
// Module      : dff_pipe_en
// Description : DEPTH-stage WIDTH-bit register pipeline with per-stage valids,
//               valid/ready flow control, bubble collapsing, hold and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dff_pipe_en #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;

  logic             w_en;
  logic [DEPTH-1:0] w_adv;
  logic             w_in_xfer;
  logic             w_out_xfer;

  // Reset forces the pipeline into hold so in_ready stays low while rst is low.
  assign w_en = en & rst;

  // A valid stage is stuck only when it and every stage after it are valid
  // and the output is blocked; otherwise the chain in front of it moves.
  always_comb begin : p_adv
    logic tail_full;
    tail_full = 1'b1;
    w_adv     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      tail_full = tail_full & valid_q[i];
      w_adv[i]  = w_en & valid_q[i] & (out_ready | ~tail_full);
    end
  end

  assign in_ready   = w_en & ~flush & (~valid_q[0] | w_adv[0]);
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = w_adv[DEPTH-1];

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    if (flush) begin
      valid_d = '0;
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = '0;
      end
    end else if (w_en) begin
      if (w_in_xfer) begin
        valid_d[0] = 1'b1;
        data_d[0]  = in_data;
      end else if (w_adv[0]) begin
        valid_d[0] = 1'b0;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_adv[i-1]) begin
          valid_d[i] = 1'b1;
          data_d[i]  = data_q[i-1];
        end else if (w_adv[i]) begin
          valid_d[i] = 1'b0;
        end
      end
      case ({w_in_xfer, w_out_xfer})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1] & w_en;
  assign out_data  = data_q[DEPTH-1];
  assign count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_dff_pipe_en.sv
// ============================================================================
// Module      : tb_dff_pipe_en
// Description : Scoreboard bench for dff_pipe_en; the model is an ordered
//               queue of accepted words whose size is the expected occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dff_pipe_en;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] model_q [$];

  dff_pipe_en #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Words in flight are lost on reset.
  always @(negedge rst) model_q.delete();

  // Monitor: samples mid-cycle, checks handshake/occupancy, scoreboards data.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("count", 32'(count), model_q.size());
      // With collapsing bubbles the input is blocked only when every stage
      // is full and the output is not draining.
      chk("in_ready", 32'(in_ready),
          32'(en & ~flush & ((model_q.size() < DEPTH) | out_ready)));
      if (!en || model_q.size() == 0) chk("out_valid_idle", 32'(out_valid), 0);
      else if (model_q.size() == DEPTH) chk("out_valid_full", 32'(out_valid), 1);
      if (flush) begin
        model_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (model_q.size() == 0) chk("spurious_out", 32'(out_valid), 0);
          else chk("out_data", 32'(out_data), 32'(model_q.pop_front()));
        end
        if (in_valid && in_ready) model_q.push_back(in_data);
      end
    end
  end

  initial begin
    rst = 1'b0; en = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    step(); step();
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    rst = 1'b1;
    step();

    // Single word latency
    in_valid = 1'b1; in_data = 8'hA5;
    step();
    in_valid = 1'b0;
    for (int j = 0; j <= DEPTH; j++) begin
      if (j > 0) step();
      chk("lat_valid", 32'(out_valid), 32'(j == DEPTH - 1));
      chk("lat_count", 32'(count), (j < DEPTH) ? 1 : 0);
      if (j == DEPTH - 1) chk("lat_data", 32'(out_data), 32'h A5);
    end

    // Back-to-back streaming
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(i);
      step();
      if (i >= DEPTH) chk("stream_count", 32'(count), DEPTH);
    end
    in_valid = 1'b0;
    repeat (DEPTH + 1) step();

    // Bubble collapse
    in_valid = 1'b1; in_data = 8'h20;
    step();
    in_valid = 1'b0;
    step(); step();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h21;
    step();
    in_valid = 1'b0;
    repeat (DEPTH) step();
    chk("bubble_count", 32'(count), 2);
    chk("bubble_out_valid", 32'(out_valid), 1);
    chk("bubble_out_data", 32'(out_data), 32'h20);
    out_ready = 1'b1;
    repeat (DEPTH + 1) step();

    // Enable hold mid-stream
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(8'h30 + i);
      step();
    end
    in_valid = 1'b1; in_data = 8'h3F; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_count", 32'(count), 3);
      chk("hold_out_valid", 32'(out_valid), 0);
      chk("hold_in_ready", 32'(in_ready), 0);
    end
    en = 1'b1; in_valid = 1'b0;
    repeat (DEPTH + 2) step();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      en        = ($urandom_range(0, 9) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_data   = WIDTH'($urandom);
      step();
    end
    en = 1'b1; out_ready = 1'b1;

    // Flush drops the presented word and clears everything
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", 32'(count), 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_out_data", 32'(out_data), 0);

    // Backpressure until full
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(8'h10 + i);
      step();
    end
    chk("full_count", 32'(count), DEPTH);
    chk("full_in_ready", 32'(in_ready), 0);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 2) step();
    chk("drain_count", 32'(count), 0);

    // Asynchronous reset between clock edges
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(8'h40 + i);
      step();
    end
    in_valid = 1'b0;
    chk("pre_arst_count", 32'(count), 2);
    #1 rst = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_out_valid", 32'(out_valid), 0);
    #1 rst = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_arst_count", 32'(count), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dff_pipe_en.md
Name: dff_pipe_en

Overview:
- Parametrised multi-stage enabled register pipeline. It is the successor to the single-bit enabled D flip-flop.
- Carries WIDTH-bit data through DEPTH register stages. Each stage has its own valid bit.
- Provides valid/ready flow control with bubble collapsing, a global enable/hold, a synchronous flush and an occupancy count.
- Used as a generic retiming/buffering stage between datapath blocks.

Parameters:
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 4, number of register stages (>=1)
- CW, $clog2(DEPTH+1), width of count output (derived, not overridden)

Ports:
- clk  input  1  clock, rising-edge
- rst  input  1  asynchronous active-low reset
- en  input  1  global enable; 0 = whole pipeline holds
- flush  input  1  synchronous clear of all stage valids
- in_valid  input  1  upstream data valid
- in_ready  output  1  pipeline can accept in_data this cycle
- in_data  input  WIDTH  upstream data
- out_valid  output  1  stage DEPTH-1 holds valid data
- out_ready  input  1  downstream accepts out_data
- out_data  output  WIDTH  data of stage DEPTH-1
- count  output  CW  number of valid stages

Behaviour:
- Reset (rst=0, async): all stage valids=0, all stage data=0, count=0. Outputs are then out_valid=0, out_data=0, in_ready=0 (en low forced by reset) or per equations after release. Release is synchronous to the next clk edge.
- Stage index 0 is the input side; stage DEPTH-1 drives out_data/out_valid directly (registered, no combinational data path in->out).
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Stage advance term adv[i]:
  - adv[DEPTH-1] = en & v[DEPTH-1] & out_ready.
  - adv[i] (i<DEPTH-1) = en & v[i] & (!v[i+1] | adv[i+1]).
  - Bubbles collapse: a stage moves forward whenever the next stage is empty or itself moving.
- Acceptance: in_ready = en & !flush & (!v[0] | adv[0]). This is a combinational ready path from out_ready; documented, no skid buffer.
- On a clk edge with en=1, flush=0:
  - stage i+1 loads data/valid from stage i when adv[i].
  - stage i+1 clears valid when adv[i+1] and !adv[i].
  - stage 0 loads in_data when an input transfer occurs; otherwise it clears valid if adv[0].
- out_valid = v[DEPTH-1] & en; en=0 hides output so no transfer can occur while held.
- en=0: no register changes (data, valids, count all hold); in_ready=0, out_valid=0.
- flush=1 at an edge: all valids cleared, all data set to 0, count=0. Flush overrides en, in_valid and out_ready. Any transfer presented that cycle is discarded (in_ready is already 0).
- Latency: on an empty, unstalled pipe, a word accepted at edge k is visible on out_data with out_valid=1 after edge k+DEPTH-1. That is DEPTH cycles from presentation. Throughput is 1 word/cycle when out_ready=1.
- Full: all DEPTH valids set. in_ready follows out_ready (simultaneous in/out transfer allowed when full; count unchanged).
- Empty: out_valid=0, in_ready=en&!flush.
- count: registered, equals popcount of stage valids after each edge. It increments on input-only transfer, decrements on output-only transfer, and is unchanged when both or neither occur. It never exceeds DEPTH.
- Reset asserted mid-stream: immediate clear regardless of clk; words in flight are lost.
- DEPTH=1: single register with valid; in_ready = en & !flush & (!v0 | out_ready).

Test Plan:
- Reset/latency (WIDTH=8, DEPTH=4): rst low 2 cycles then high, en=1, out_ready=1, send 0xA5 for one cycle -> out_valid rises 4 cycles later with out_data=0xA5 for exactly one cycle; count goes 1,1,1,1,0.
- Streaming: send 0x01..0x08 back-to-back, out_ready=1 -> outputs 0x01..0x08 in order on consecutive cycles, in_ready held 1, count steady at 4 mid-stream.
- Backpressure/full: out_ready=0, in_valid=1 with 0x10..0x15 -> exactly 4 words accepted, in_ready=0 after the 4th, count=4. Raise out_ready -> 0x10..0x13 emerge in order with no loss or duplication.
- Bubble collapse: send 0x20, idle 2 cycles, send 0x21 with out_ready=0 -> after 4 cycles v[3]=v[2]=1 (words adjacent), count=2.
- Enable hold: mid-stream drop en for 3 cycles -> in_ready=0, out_valid=0, count and all data frozen. Raise en -> sequence resumes unchanged.
- Flush and async reset: with count=3 assert flush for 1 cycle with in_valid=1 -> count=0, out_valid=0, input word dropped. Later pulse rst low between clk edges with count=2 -> count and out_valid go 0 immediately.
